serial_subtractor: RTL

Bit-serial two's-complement subtractor for the Laplace filter datapath: computes A − B one bit per clock with a single full-subtractor cell, LSB first. It is the inverse operation to the existing full-adder datapath and serves as the area-cheap difference stage for neighbour-minus-centre terms. Operands are accepted with a start/ready handshake, and the result is presented with a one-cycle `done` pulse.

---
 rtl/laplace_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 4 files changed

// File: rtl/laplace_pkg.sv
// Shared definitions for the Laplace filter datapath.
//   PIX_W   : default pixel/datapath width
//   state_e : control states of the bit-serial subtractor
package laplace_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
//   master : drives start/a/b, observes ready/busy/done and the result
//   slave  : the subtractor side
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = laplace_pkg::PIX_W
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow, overflow
  );

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of serial_subtractor_if (start/a/b in; ready/busy/done,
//         diff/borrow/overflow out). Results are held until the next op completes.
module serial_subtractor
  import laplace_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        bin_d  = fs_bout;
        if (cnt_q == LastBit) begin
          // Commit on the edge that enters DONE; the last bit is the sign bit.
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
          ovf_d    = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  // ready is masked by rst so a start during reset is never advertised as accepted.
  assign bus.ready    = (state_q == IDLE) & ~rst;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;

endmodule
